// File: rtl/hls_cdp_icvt_pkg.sv
// Shared constants and types for the CDP input-convert output channel.
// Optional feature macro used by this slice: CDP_ICVT_OUT_PERF_EN.
package hls_cdp_icvt_pkg;

    // Default data width of the core write port and downstream bus.
    localparam int DEFAULT_WIDTH = 64;

    // Default number of buffered entries (legal range 2..8).
    localparam int DEFAULT_DEPTH = 2;

    // Width of the optional stall performance counters.
    localparam int PERF_CNT_W = 32;

    // Pointer width needed to address `depth` entries (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Pointer type for the default depth; modules with an overridden DEPTH
    // derive their own local pointer type from ptr_w(DEPTH).
    typedef logic [ptr_w(DEFAULT_DEPTH)-1:0] ptr_t;

endpackage : hls_cdp_icvt_pkg

// File: rtl/hls_cdp_icvt_out_skid_fifo.sv
// Small output FIFO for the CDP input-convert channel.
// Keeps storage, pointers, occupancy, a registered full flag and a
// registered head/valid pair so nothing downstream reaches the core stall
// combinationally. DEPTH need not be a power of two.
module hls_cdp_icvt_out_skid_fifo
    import hls_cdp_icvt_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full
);

    localparam int PW = ptr_w(DEPTH);
    typedef logic [PW-1:0] idx_t;

    // Advance a pointer, wrapping at DEPTH rather than at a power of two.
    function automatic idx_t wrap_inc(input idx_t p);
        return (p == idx_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];

    idx_t             rd_ptr_q, rd_ptr_d;
    idx_t             wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] head_q,   head_d;
    logic             full_q;
    logic             valid_q;

    // Next-state for pointers, occupancy and the registered head.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (pop) begin
            rd_ptr_d = wrap_inc(rd_ptr_q);
        end
        if (push) begin
            wr_ptr_d = wrap_inc(wr_ptr_q);
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        // The new head is the entry at the next read pointer; if that slot is
        // the one being written this cycle, take the incoming data directly.
        // When the FIFO goes empty the last head value is held.
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = push_data;
            end else begin
                head_d = mem[rd_ptr_d];
            end
        end
    end

    // Control state: pointers, occupancy, flags and the head register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            full_q   <= (count_d == CW'(DEPTH));
            valid_q  <= (count_d != '0);
        end
    end

    // Storage write on push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; its contents are only read
        // after being written, and a reset here would cost a reset net per bit.
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head  = head_q;
    assign valid = valid_q;
    assign full  = full_q;

endmodule : hls_cdp_icvt_out_skid_fifo

// File: rtl/hls_cdp_icvt_chn_data_out_rsci.sv
// Output-channel interface of the CDP input-convert HLS core.
// Produces the channel's contribution to the core write enable from a
// registered full flag (never from downstream ready), buffers core writes in
// a small FIFO and drives the lz/vz handshake downstream.
// Optional feature macro: CDP_ICVT_OUT_PERF_EN adds two saturating stall
// counters as extra outputs.
module hls_cdp_icvt_chn_data_out_rsci
    import hls_cdp_icvt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    input  logic                  core_req,
    input  logic [WIDTH-1:0]      core_data,
    input  logic                  core_wen,
    input  logic                  core_wten,
    output logic                  chn_data_out_rsci_wen_comp,
    output logic [WIDTH-1:0]      chn_data_out_rsc_z,
    output logic                  chn_data_out_rsc_lz,
    input  logic                  chn_data_out_rsc_vz
`ifdef CDP_ICVT_OUT_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_out_stall_cnt,
    output logic [PERF_CNT_W-1:0] perf_core_stall_cnt
`endif
);

    logic full;
    logic push;
    logic pop;

    // Stall only while the core wants to write and the buffer was already
    // full at the last edge; a pop in the same cycle is not credited until
    // the next cycle, which keeps downstream ready off the stall path.
    assign chn_data_out_rsci_wen_comp = ~core_req | ~full;

    // core_wen already folds in wen_comp, so a push can never hit a full FIFO.
    assign push = core_req & core_wen;
    assign pop  = chn_data_out_rsc_lz & chn_data_out_rsc_vz;

    hls_cdp_icvt_out_skid_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (nvdla_core_clk),
        .rst_n     (nvdla_core_rstn),
        .push      (push),
        .push_data (core_data),
        .pop       (pop),
        .head      (chn_data_out_rsc_z),
        .valid     (chn_data_out_rsc_lz),
        .full      (full)
    );

`ifdef CDP_ICVT_OUT_PERF_EN
    logic [PERF_CNT_W-1:0] perf_out_stall_q;
    logic [PERF_CNT_W-1:0] perf_core_stall_q;

    // Saturating count of cycles in which this channel held the core back.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            perf_out_stall_q <= '0;
        end else if (core_req && !chn_data_out_rsci_wen_comp && (perf_out_stall_q != '1)) begin
            perf_out_stall_q <= perf_out_stall_q + 1'b1;
        end
    end

    // Saturating count of cycles following a core stall from any channel.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            perf_core_stall_q <= '0;
        end else if (core_wten && (perf_core_stall_q != '1)) begin
            perf_core_stall_q <= perf_core_stall_q + 1'b1;
        end
    end

    assign perf_out_stall_cnt  = perf_out_stall_q;
    assign perf_core_stall_cnt = perf_core_stall_q;
`else
    // Performance counters are not built in this configuration.
`endif

`ifndef SYNTHESIS
    logic wen_d_q;
    logic past_valid_q;

    // Remember the previous core_wen to cross-check the staller's core_wten.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wen_d_q      <= 1'b1;
            past_valid_q <= 1'b0;
        end else begin
            wen_d_q      <= core_wen;
            past_valid_q <= 1'b1;
        end
    end

    a_no_push_when_full : assert property (
        @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        push |-> !full);

    a_no_pop_when_empty : assert property (
        @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        pop |-> chn_data_out_rsc_lz);

    a_z_stable_when_stalled : assert property (
        @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        (chn_data_out_rsc_lz && !chn_data_out_rsc_vz) |=> $stable(chn_data_out_rsc_z));

    a_wten_tracks_wen : assert property (
        @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        past_valid_q |-> (core_wten == !wen_d_q));
`endif

endmodule : hls_cdp_icvt_chn_data_out_rsci

// File: tb/tb_hls_cdp_icvt_chn_data_out_rsci.sv
// Bench for the CDP input-convert output channel: directed stimulus, a
// queue-based reference of the buffered stream compared every cycle, and
// hand-computed expectations at the interesting points.
module tb_hls_cdp_icvt_chn_data_out_rsci;

    localparam int WIDTH = 64;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             core_req = 1'b0;
    logic [WIDTH-1:0] core_data = '0;
    logic             core_wen = 1'b1;
    logic             core_wten = 1'b0;
    logic             wen_comp;
    logic [WIDTH-1:0] z;
    logic             lz;
    logic             vz = 1'b0;
`ifdef CDP_ICVT_OUT_PERF_EN
    logic [31:0]      perf_out;
    logic [31:0]      perf_core;
`endif

    int checks = 0;
    int errors = 0;
    logic wen_prev = 1'b1;

    // Reference: contents of the buffer in order, plus the last head shown.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_last = '0;
    logic [WIDTH-1:0] dut_rx[$];

    always #5 clk = ~clk;

    hls_cdp_icvt_chn_data_out_rsci #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .nvdla_core_clk             (clk),
        .nvdla_core_rstn            (rstn),
        .core_req                   (core_req),
        .core_data                  (core_data),
        .core_wen                   (core_wen),
        .core_wten                  (core_wten),
        .chn_data_out_rsci_wen_comp (wen_comp),
        .chn_data_out_rsc_z         (z),
        .chn_data_out_rsc_lz        (lz),
        .chn_data_out_rsc_vz        (vz)
`ifdef CDP_ICVT_OUT_PERF_EN
        ,
        .perf_out_stall_cnt         (perf_out),
        .perf_core_stall_cnt        (perf_core)
`endif
    );

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One core cycle: inputs change at the falling edge, then the staller
    // combines this channel's wen_comp with the other channels' readiness.
    task automatic step(input logic req, input logic [WIDTH-1:0] data,
                        input logic ready, input logic other_ok);
        @(negedge clk);
        core_req  = req;
        core_data = data;
        vz        = ready;
        core_wten = ~wen_prev;
        #1;
        core_wen  = other_ok & wen_comp;
        wen_prev  = core_wen;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Reference update: a write enters the tail, an accepted beat leaves the head.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            m_last = '0;
        end else begin
            logic do_push;
            logic do_pop;
            do_push = core_req & core_wen;
            do_pop  = (mq.size() != 0) & vz;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(core_data);
            if (mq.size() != 0) m_last = mq[0];
        end
    end

    // Per-cycle comparison, well after inputs settle and away from the edge.
    always @(negedge clk) begin
        #3;
        if (rstn) begin
            logic [WIDTH-1:0] exp_z;
            exp_z = (mq.size() != 0) ? mq[0] : m_last;
            check("lz", 64'(lz), 64'(mq.size() != 0));
            check("z", z, exp_z);
            check("wen_comp", 64'(wen_comp), 64'(!core_req || (mq.size() != DEPTH)));
            if (lz && vz) dut_rx.push_back(z);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;

        // Reset then idle.
        repeat (3) step(1'b0, '0, 1'b0, 1'b1);
        rstn = 1'b1;
        step(1'b0, '0, 1'b0, 1'b1);
        after_edge();
        check("rst_wen_comp", 64'(wen_comp), 64'd1);
        check("rst_lz", 64'(lz), 64'd0);
        check("rst_z", z, 64'h0);

        // Single beat with downstream always ready.
        step(1'b1, 64'hA5, 1'b1, 1'b1);
        after_edge();
        check("a5_lz", 64'(lz), 64'd1);
        check("a5_z", z, 64'hA5);
        step(1'b0, '0, 1'b1, 1'b1);
        after_edge();
        check("a5_drained_lz", 64'(lz), 64'd0);
        check("a5_hold_z", z, 64'hA5);

        // Fill with downstream blocked, then release.
        step(1'b1, 64'h11, 1'b0, 1'b1);
        step(1'b1, 64'h22, 1'b0, 1'b1);
        step(1'b1, 64'h33, 1'b0, 1'b1);
        check("full_wen_comp", 64'(wen_comp), 64'd0);
        check("full_no_push", 64'(core_wen), 64'd0);
        check("full_head", z, 64'h11);
        step(1'b1, 64'h33, 1'b1, 1'b0);
        check("full_pop_wen_comp", 64'(wen_comp), 64'd0);
        after_edge();
        check("after_pop_z", z, 64'h22);
        check("after_pop_lz", 64'(lz), 64'd1);
        step(1'b1, 64'h33, 1'b0, 1'b0);
        check("space_wen_comp", 64'(wen_comp), 64'd1);
        step(1'b0, '0, 1'b1, 1'b1);
        after_edge();
        check("drain_lz", 64'(lz), 64'd0);
        check("drain_z", z, 64'h22);

        // Steady stream through a full buffer.
        dut_rx.delete();
        idx = 0;
        for (int cyc = 0; cyc < 200 && idx < 16; cyc++) begin
            step(1'b1, 64'(idx), 1'b1, 1'b1);
            if (core_wen) idx++;
        end
        check("stream_sent", 64'(idx), 64'd16);
        repeat (4) step(1'b0, '0, 1'b1, 1'b1);
        check("stream_count", 64'(dut_rx.size()), 64'd16);
        for (int i = 0; i < 16 && i < dut_rx.size(); i++) begin
            check("stream_order", dut_rx[i], 64'(i));
        end

        // Another channel stalls the core while this one requests.
        step(1'b1, 64'h55, 1'b0, 1'b1);
        repeat (3) step(1'b1, 64'hDEAD, 1'b0, 1'b0);
        after_edge();
        check("stall_lz", 64'(lz), 64'd1);
        check("stall_z", z, 64'h55);
        step(1'b0, '0, 1'b1, 1'b1);
        after_edge();
        check("stall_drain_lz", 64'(lz), 64'd0);
        check("stall_drain_z", z, 64'h55);

`ifdef CDP_ICVT_OUT_PERF_EN
        begin
            logic [31:0] base;
            base = perf_out;
            step(1'b1, 64'h1, 1'b0, 1'b1);
            step(1'b1, 64'h2, 1'b0, 1'b1);
            repeat (10) step(1'b1, 64'h3, 1'b0, 1'b1);
            after_edge();
            check("perf_out_10", 64'(perf_out - base), 64'd10);
            repeat (3) step(1'b0, '0, 1'b1, 1'b1);
            base = perf_core;
            repeat (4) step(1'b0, '0, 1'b1, 1'b0);
            step(1'b0, '0, 1'b1, 1'b1);
            after_edge();
            check("perf_core_4", 64'(perf_core - base), 64'd4);
            step(1'b1, 64'h1, 1'b0, 1'b1);
            step(1'b1, 64'h2, 1'b0, 1'b1);
            step(1'b1, 64'h3, 1'b0, 1'b1);
            force dut.perf_out_stall_q = 32'hFFFF_FFFD;
            #1;
            release dut.perf_out_stall_q;
            repeat (4) step(1'b1, 64'h3, 1'b0, 1'b1);
            after_edge();
            check("perf_out_sat", 64'(perf_out), 64'hFFFF_FFFF);
            repeat (3) step(1'b0, '0, 1'b1, 1'b1);
        end
`endif

        // Reset while data is buffered: valid drops without a clock edge.
        step(1'b1, 64'h77, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        check("pre_reset_lz", 64'(lz), 64'd1);
        rstn = 1'b0;
        #1;
        check("async_rst_lz", 64'(lz), 64'd0);
        check("async_rst_z", z, 64'h0);
        check("async_rst_wen_comp", 64'(wen_comp), 64'd1);
        repeat (2) step(1'b0, '0, 1'b0, 1'b1);
        rstn = 1'b1;
        repeat (2) step(1'b0, '0, 1'b1, 1'b1);
        after_edge();
        check("post_reset_lz", 64'(lz), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_hls_cdp_icvt_chn_data_out_rsci

// File: doc/hls_cdp_icvt_chn_data_out_rsci.md
Name: hls_cdp_icvt_chn_data_out_rsci

Overview:
- Output-channel interface for the CDP input-convert HLS core.
- Produces the `chn_data_out_rsci_wen_comp` term that the core staller ANDs into `core_wen`, so it is the producer end of the staller's handshake.
- Buffers core write data in a small FIFO and drives a valid/ready (lz/vz) handshake to the downstream consumer.
- The design removes any combinational path from downstream ready to core stall.

Parameters:
- WIDTH, 64: data width of the core write and the downstream data bus.
- DEPTH, 2: FIFO entries. Legal values: 2..8.
- CW, $clog2(DEPTH+1): occupancy counter width (derived; do not override).

Ports:
- nvdla_core_clk  in  1  core clock, all state on rising edge.
- nvdla_core_rstn  in  1  asynchronous active-low reset.
- core_req  in  1  core wants to write `core_data` this cycle.
- core_data  in  WIDTH  write data, valid when `core_req`=1.
- core_wen  in  1  global advance enable from the staller; the core commits this cycle.
- core_wten  in  1  registered ~`core_wen` from the staller; means the core was stalled last cycle.
- chn_data_out_rsci_wen_comp  out  1  this channel does not stall the core.
- chn_data_out_rsc_z  out  WIDTH  downstream data (FIFO head).
- chn_data_out_rsc_lz  out  1  downstream valid.
- chn_data_out_rsc_vz  in  1  downstream ready.

Behaviour:
- Reset (async assert, sync release):
  - occupancy=0, read and write pointers=0, `lz`=0, `z`=0, `wen_comp`=1 (because full=0).
  - Storage contents are don't-care.
- `wen_comp` = ~`core_req` | ~full_q.
  - full_q is a registered flag: occupancy==DEPTH.
  - `wen_comp` never depends combinationally on `vz`.
- push = `core_req` & `core_wen`. Because `core_wen` already includes `wen_comp`, a push never occurs when full.
- pop = `lz` & `vz`.
- `lz` = occupancy!=0 (registered). `z` = storage[rd_ptr]; it is held stable while `lz`=1 and `vz`=0.
- Occupancy update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
  - Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Latency: data pushed in cycle N appears on `z` with `lz`=1 in cycle N+1 (single-register fall-through, no bypass).
- Full with simultaneous pop: `wen_comp` stays 0 that cycle (conservative). Space is visible from the next cycle.
- Empty: `z` holds the last head value; `vz` is ignored.
- `core_req`=1 and `core_wen`=0 caused by another channel: no push, `core_data` is not sampled, and the FIFO may still drain.
- Reset mid-transfer: all buffered data is discarded and `lz` drops immediately (asynchronously).
- Assertions (sim only):
  - No push when full.
  - No pop when empty.
  - `z` stable while `lz` & ~`vz`.
  - `core_wten` equals ~`core_wen` delayed by one cycle.

Optional Feature:
- Macro: CDP_ICVT_OUT_PERF_EN.
- Defined:
  - Adds outputs `perf_out_stall_cnt` [31:0] and `perf_core_stall_cnt` [31:0].
  - `perf_out_stall_cnt` increments on each cycle with `core_req` & ~`wen_comp`.
  - `perf_core_stall_cnt` increments on each cycle with `core_wten`=1.
  - Both counters saturate at 32'hFFFF_FFFF, reset to 0, and have no clear input.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package hls_cdp_icvt_pkg holds:
  - Default WIDTH and DEPTH constants.
  - PERF_CNT_W=32.
  - A ptr_t typedef function of DEPTH.
- One sub-module: hls_cdp_icvt_out_skid_fifo.
  - Contains storage, pointers, occupancy, full_q, and the `lz`/`z` drive.
  - Ports: push, push_data, pop, head, valid, full.
- The top level adds the `wen_comp` logic, the push/pop qualification and the optional perf counters.

Test Plan:
- Reset then idle, `core_req`=0 → `wen_comp`=1, `lz`=0, `z`=0. Assert rstn low mid-cycle → `lz` falls without a clock edge.
- `vz`=1 constant; push 0xA5 at cycle 5 with `core_wen`=1 → `lz`=1 and `z`=0xA5 at cycle 6, `lz`=0 at cycle 7.
- `vz`=0; push 0x11 then 0x22 (DEPTH=2) → occupancy 2, `wen_comp`=0 while `core_req`=1. Raise `vz` → pop order 0x11, 0x22; `wen_comp`=1 the cycle after the first pop.
- Full with `core_req`=1, `vz`=1 and push+pop in a steady stream of 0x00..0x0F → every value delivered once, in order, none lost or duplicated.
- `core_req`=1 and `core_wen`=0 (other channel stalling) for 3 cycles with `core_data`=0xDEAD → no push, occupancy unchanged.
- PERF_EN: hold full 10 cycles with `core_req`=1 → `perf_out_stall_cnt`=10. Force `core_wten`=1 for 4 cycles → `perf_core_stall_cnt`=4. Preload near saturation → counter stays at 0xFFFF_FFFF.
